// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops a programmed burst from the FIFO read port onto a valid/ready stream
// Optional stall counter output enabled by defining FIFO_BURST_READER_STALL_CNT_EN.
module fifo_burst_reader #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk_w,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] burst_len,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_rdata,
   output logic             fifo_rd_en,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] words_done
`ifdef FIFO_BURST_READER_STALL_CNT_EN
   ,
   output logic [15:0]      stall_cycles
`endif
);

   if (DEPTH < 1) begin : g_depth_check
      $error("fifo_burst_reader: DEPTH must be at least 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam logic [LEN_W-1:0] LEN_ONE = 1;

   state_t           state;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] issued;
   logic             inflight;
   logic [WIDTH-1:0] buf_q [3];
   logic [1:0]       head;
   logic [1:0]       count;
   logic [1:0]       tail;
   logic [1:0]       head_nxt;
   logic [2:0]       tail_sum;
   logic             xfer;
   logic             pop;

   assign m_valid = (count != 2'd0);
   assign m_data  = buf_q[head];
   assign xfer    = m_valid && m_ready;

   // Pop budget counts words already buffered plus the one still in the FIFO read pipeline.
   assign pop = (state == S_READ) && !fifo_empty && (issued < len) &&
                (({1'b0, count} + {2'b00, inflight}) < 3'd3);
   assign fifo_rd_en = pop;

   always_comb begin
      tail_sum = {1'b0, head} + {1'b0, count};
      tail     = (tail_sum >= 3'd3) ? 2'(tail_sum - 3'd3) : tail_sum[1:0];
      head_nxt = (head == 2'd2) ? 2'd0 : head + 2'd1;
   end

   always_ff @(posedge clk_w or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         len        <= '0;
         issued     <= '0;
         inflight   <= 1'b0;
         head       <= 2'd0;
         count      <= 2'd0;
         words_done <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
         for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      end else begin
         done     <= 1'b0;
         inflight <= pop;
         count    <= count + {1'b0, inflight} - {1'b0, xfer};
         if (pop) issued <= issued + LEN_ONE;
         if (inflight) buf_q[tail] <= fifo_rdata;
         if (xfer) begin
            head       <= head_nxt;
            words_done <= words_done + LEN_ONE;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  len        <= burst_len;
                  issued     <= '0;
                  words_done <= '0;
                  busy       <= 1'b1;
                  if (burst_len == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (pop && (issued + LEN_ONE == len)) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!inflight && count == 2'd1 && xfer) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef FIFO_BURST_READER_STALL_CNT_EN
   always_ff @(posedge clk_w or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (state == S_IDLE && start) begin
         stall_cycles <= '0;
      end else if (state == S_READ && issued < len && fifo_empty && stall_cycles != 16'hFFFF) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader with a queue-based FIFO and scoreboard
module tb_fifo_burst_reader;

   logic        clk_w = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  burst_len = 4'd0;
   logic        fifo_empty = 1'b1;
   logic [31:0] fifo_rdata = 32'd0;
   logic        fifo_rd_en;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] m_data;
   logic        busy;
   logic        done;
   logic [3:0]  words_done;
`ifdef FIFO_BURST_READER_STALL_CNT_EN
   logic [15:0] stall_cycles;
`endif

   fifo_burst_reader #(.WIDTH(32), .DEPTH(8), .LEN_W(4)) dut (
      .clk_w      (clk_w),
      .rst_n      (rst_n),
      .start      (start),
      .burst_len  (burst_len),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_rd_en (fifo_rd_en),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .busy       (busy),
      .done       (done),
      .words_done (words_done)
`ifdef FIFO_BURST_READER_STALL_CNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk_w = ~clk_w;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural FIFO: data_out registered one cycle after an accepted pop.
   logic [31:0] fq [$];
   logic        push_en = 1'b0;
   logic [31:0] push_word = 32'd0;
   int          pops_total = 0;
   int          cyc = 0;

   always @(posedge clk_w) begin
      if (fifo_rd_en && fq.size() != 0) begin
         fifo_rdata <= fq.pop_front();
         pops_total <= pops_total + 1;
      end
      if (push_en) fq.push_back(push_word);
      fifo_empty <= (fq.size() == 0);
   end

   always @(posedge clk_w) cyc <= cyc + 1;

   logic [31:0] written [$];
   logic [31:0] list_a [8];
   logic [31:0] list_b [3];
   int          ready_mode = 0;
   int          rphase = 0;

   initial forever begin
      @(posedge clk_w);
      #1;
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = (rphase == 0 || rphase == 3);
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
      rphase = (rphase + 1) % 4;
   end

   // Scoreboard: the burst must deliver, in order, the words written right after those already consumed.
   bit          active = 0;
   bit          win = 0;
   int          base = 0;
   int          cur_len = 0;
   int          delivered = 0;
   int          rd_pulses = 0;
   int          done_cnt = 0;
   int          stall_exp = 0;
   int          first_rd = -1;
   int          first_val = -1;
   int          last_xfer = -1;
   int          done_cyc = -1;
   logic        hold = 1'b0;
   logic [31:0] hold_data = 32'd0;

   always @(negedge clk_w) begin
      if (active && rst_n) begin
         check("rd_en_while_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
         check("outstanding_le_3", {31'd0, (pops_total - base - delivered) <= 3}, 32'd1);
         if (fifo_rd_en) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc;
         end
         if (m_valid && first_val < 0) first_val = cyc;
         if (hold) begin
            check("hold_valid", {31'd0, m_valid}, 32'd1);
            check("hold_data", m_data, hold_data);
         end
         if (m_valid && m_ready) begin
            check("word_in_range", {31'd0, delivered < cur_len}, 32'd1);
            if (base + delivered < written.size())
               check("m_data", m_data, written[base + delivered]);
            delivered++;
            last_xfer = cyc;
         end
         hold      = m_valid && !m_ready;
         hold_data = m_data;
         if (win && fifo_empty && (pops_total - base) < cur_len) stall_exp++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            win = 0;
         end
      end
   end

   task automatic push_one(input logic [31:0] w);
      @(posedge clk_w);
      #1;
      push_en   = 1'b1;
      push_word = w;
      written.push_back(w);
   endtask

   task automatic begin_burst(input int len, output int s_cyc);
      @(posedge clk_w);
      #1;
      base = pops_total; cur_len = len; delivered = 0; rd_pulses = 0; done_cnt = 0;
      stall_exp = 0; first_rd = -1; first_val = -1; last_xfer = -1; done_cyc = -1;
      hold = 1'b0; active = 1;
      start = 1'b1; burst_len = 4'(len); s_cyc = cyc;
      @(posedge clk_w);
      #1;
      start = 1'b0; win = 1;
   endtask

   task automatic run_burst(input int len, input int prefill_n, input int late_n, input int late_delay,
                            input int mode, input int src, input bit poke, input bit chk_lat,
                            input int exp_wd, input int exp_pops);
      logic [31:0] words [$];
      int s_cyc;
      for (int i = 0; i < prefill_n + late_n; i++)
         words.push_back(src == 1 ? list_a[i] : (src == 2 ? list_b[i] : $urandom()));
      for (int i = 0; i < prefill_n; i++) push_one(words[i]);
      @(posedge clk_w);
      #1;
      push_en = 1'b0;
      repeat (2) @(posedge clk_w);
      ready_mode = mode;
      begin_burst(len, s_cyc);
      fork
         begin
            if (late_n > 0) begin
               repeat (late_delay) @(posedge clk_w);
               for (int i = 0; i < late_n; i++) push_one(words[prefill_n + i]);
               @(posedge clk_w);
               #1;
               push_en = 1'b0;
            end
         end
         begin
            if (poke) begin
               repeat (3) @(posedge clk_w);
               #1;
               start = 1'b1; burst_len = 4'd2;
               @(posedge clk_w);
               #1;
               start = 1'b0; burst_len = 4'(len);
            end
         end
         begin
            for (int t = 0; t < 3000 && done_cnt == 0; t++) @(posedge clk_w);
         end
      join
      check("done_seen", {31'd0, done_cnt > 0}, 32'd1);
      repeat (3) @(posedge clk_w);
      #1;
      check("done_once", done_cnt, 32'd1);
      check("words_done", {28'd0, words_done}, exp_wd);
      check("rd_en_count", rd_pulses, exp_pops);
      check("delivered", delivered, exp_wd);
      check("busy_idle", {31'd0, busy}, 32'd0);
      if (chk_lat) begin
         check("first_rd_cycle", first_rd, s_cyc + 1);
         check("first_valid_cycle", first_val, s_cyc + 3);
         check("last_xfer_cycle", last_xfer, s_cyc + 2 + len);
         check("done_cycle", done_cyc, last_xfer + 1);
      end
`ifdef FIFO_BURST_READER_STALL_CNT_EN
      check("stall_cycles", {16'd0, stall_cycles}, stall_exp);
`endif
      active = 0;
      win = 0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
      check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
      check({tag, "_m_data"}, m_data, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_words_done"}, {28'd0, words_done}, 32'd0);
   endtask

   typedef struct {
      int len; int prefill; int late; int delay; int mode; int src;
      bit poke; bit chk_lat; int exp_wd; int exp_pops;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int s_cyc;
      list_a = '{32'h1234ABCD, 32'h14AC1268, 32'h4D4D4D67, 32'h8E7E6E5E,
                 32'hEEE54678, 32'hAAAAA543, 32'hFFFFFFFA, 32'hCECECECE};
      list_b = '{32'hCAFEBABE, 32'hBABABABA, 32'h12345678};
      tbl[0] = '{8, 8, 0, 0, 0, 1, 1'b0, 1'b1, 8, 8};
      tbl[1] = '{8, 8, 0, 0, 1, 1, 1'b0, 1'b0, 8, 8};
      tbl[2] = '{3, 0, 3, 20, 0, 2, 1'b0, 1'b0, 3, 3};
      tbl[3] = '{8, 8, 0, 0, 2, 0, 1'b1, 1'b0, 8, 8};
      tbl[4] = '{15, 4, 11, 5, 2, 0, 1'b0, 1'b0, 15, 15};
      tbl[5] = '{1, 1, 0, 0, 0, 0, 1'b0, 1'b1, 1, 1};

      repeat (3) @(posedge clk_w);
      #1;
      check_outputs_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk_w);

      foreach (tbl[i])
         run_burst(tbl[i].len, tbl[i].prefill, tbl[i].late, tbl[i].delay, tbl[i].mode,
                   tbl[i].src, tbl[i].poke, tbl[i].chk_lat, tbl[i].exp_wd, tbl[i].exp_pops);

      // Zero-length burst: straight to DONE with no FIFO traffic.
      ready_mode = 0;
      begin_burst(0, s_cyc);
      check("zero_done", {31'd0, done}, 32'd1);
      check("zero_busy", {31'd0, busy}, 32'd1);
      check("zero_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      @(posedge clk_w);
      #1;
      check("zero_done_clear", {31'd0, done}, 32'd0);
      check("zero_idle", {31'd0, busy}, 32'd0);
      check("zero_words_done", {28'd0, words_done}, 32'd0);
      check("zero_no_pops", rd_pulses, 32'd0);
      active = 0; win = 0;

      // Reset after three words: everything clears at once, then a fresh burst resumes the FIFO stream.
      for (int i = 0; i < 8; i++) push_one($urandom());
      @(posedge clk_w);
      #1;
      push_en = 1'b0;
      repeat (2) @(posedge clk_w);
      begin_burst(8, s_cyc);
      for (int t = 0; t < 100 && delivered < 3; t++) @(posedge clk_w);
      check("pre_reset_delivered", delivered, 32'd3);
      #2;
      rst_n = 1'b0;
      active = 0; win = 0;
      #1;
      check_outputs_zero("midrst");
      @(posedge clk_w);
      #1;
      check_outputs_zero("midrst_hold");
      rst_n = 1'b1;
      run_burst(5, 5, 0, 0, 0, 0, 1'b0, 1'b0, 5, 5);

      for (int r = 0; r < 20; r++) begin
         int len, pre;
         len = $urandom_range(1, 15);
         pre = $urandom_range(0, len);
         run_burst(len, pre, len - pre, $urandom_range(0, 10), $urandom_range(0, 2),
                   0, 1'b0, 1'b0, len, len);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
